kbest_stream_sorter: RTL and testbench
======================================

Name: kbest_stream_sorter

Overview:
- Parametrised streaming K-best selector. Successor to the fixed 8-in/4-out bitonic top-4 sorter.
- Accepts a query's candidates as a sequence of K-lane beats and keeps a running sorted list of the K smallest (data, idx) pairs.
- Emits that list once per query, after the beat marked last.
- Sits between the distance-compute array and the match writeback. Adds ready/valid backpressure, lane masking, deterministic tie-breaking and a candidate count.

Parameters:
- DATA_W, 11, candidate distance width.
- IDX_W, 15, candidate index width.
- K, 4, lanes per beat and list length; power of 2, legal range 2..16.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_last  input  1  final beat of current query
- in_mask  input  K  per-lane candidate valid; bit i qualifies lane i
- in_data  input  K*DATA_W  lane i at [i*DATA_W +: DATA_W]
- in_idx  input  K*IDX_W  lane i at [i*IDX_W +: IDX_W]
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  result accepted when out_valid && out_ready
- out_data  output  K*DATA_W  ascending; slot 0 = smallest
- out_idx  output  K*IDX_W  idx paired with out_data slot
- out_count  output  $clog2(K)+1  real candidates in result, min(K, total unmasked lanes in query)

Behaviour:
- Reset is asynchronous on rst_n low: every register clears, including all pipeline stages, the accumulator and the result.
  - out_valid, out_data, out_idx and out_count read 0.
  - in_ready=1 once rst_n is high.
  - Query state returns to "first beat pending".
- Ordering key is the concatenation {data, idx}, compared unsigned. Equal data resolves to the smaller idx first. Output is fully deterministic.
- Masked lane handling (in_mask bit = 0):
  - Lane is replaced at capture by the sentinel: data all-ones, idx all-ones.
  - Lane does not count toward out_count.
- Stall and handshake:
  - Global enable en = !(out_valid && !out_ready); in_ready = en.
  - When en=0, every pipeline stage, the accumulator and the query counter hold.
- Sort pipeline:
  - Full bitonic sort of the K lanes, one register per compare stage.
  - S = log2(K)*(log2(K)+1)/2 stages (K=4: S=3).
  - The in_last flag and the beat's popcount(in_mask) travel with the data.
- Merge stage, single cycle, combinational into the accumulator:
  - Bitonic half-cleaner of the sorted beat against the reversed accumulator; keep the K minima, then log2(K) cleanup levels.
  - Accumulator is replaced by the sorted K smallest of the 2K entries.
  - If the beat is the first of its query, the merge partner is an all-sentinel list, not the stale accumulator.
- Count: running sum of beat popcounts per query, saturating at K; restarts on the first beat of each query.
- Result:
  - When the beat carrying in_last merges, the merged list and count load into the result register and out_valid=1.
  - The first-pending flag sets, so the next beat starts a new query with no bubble.
- Latency: accept of the last beat to out_valid = S+1 cycles with no stall (K=4: 4). Throughput is one beat per cycle.
- Result register behaviour:
  - out_valid && out_ready with no new result that cycle: out_valid drops.
  - Completion in the same cycle as acceptance: the new result loads and out_valid stays 1.
  - Outputs are stable while out_valid && !out_ready.
- A query of only masked lanes gives all-sentinel output, out_count=0, out_valid still pulses.
- in_valid=0 cycles inside a query are allowed; the accumulator holds.
- Reset mid-query discards all in-flight beats. No out_valid is produced for that query.

Test Plan (K=4):
- Reset, rst_n low 3 cycles -> out_valid=0, all outputs 0; in_ready=1 after release.
- Single beat, last=1, mask=1111, data {9,3,7,1}, idx {10,11,12,13} -> 4 cycles later out_data {1,3,7,9}, out_idx {13,11,12,10}, out_count=4, out_valid one cycle with out_ready=1.
- Two-beat query: data {50,40,30,20} idx {0,1,2,3}, then data {5,60,25,45} idx {4,5,6,7} last -> out_data {5,20,25,30}, out_idx {4,3,6,2}, out_count=4. Immediately followed by a one-beat query data {2,2,2,2} idx {3,1,2,0} -> next result out_idx {0,1,2,3}, with no leakage from the previous query.
- Partial mask 0011, data {6,2,x,x}, last -> out_data {2,6,0x7FF,0x7FF}, out_count=2. All-masked query -> out_count=0, out_valid pulses.
- Backpressure: hold out_ready=0 with a result pending while streaming a second query -> in_ready=0, outputs stable, no beats lost. Raise out_ready -> first result accepted, second result correct, S+1 cycles plus stall duration.
- Drop rst_n mid-way through a 3-beat query -> no out_valid. A fresh query after reset produces a correct result with no leakage from the aborted query.

Source files
------------

// File: rtl/kbest_stream_sorter_if.sv
// Handshake bundle for the streaming K-best selector.
//   in_*  : candidate beats (K lanes, per-lane mask, last-beat flag), ready/valid
//   out_* : sorted K-best result with candidate count, ready/valid
// master drives beats and consumes results; slave is the selector itself.
interface kbest_stream_sorter_if #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned IDX_W  = 15,
    parameter int unsigned K      = 4
);
    localparam int unsigned CntW = $clog2(K) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [K-1:0]          in_mask;
    logic [K*DATA_W-1:0]   in_data;
    logic [K*IDX_W-1:0]    in_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic [K*DATA_W-1:0]   out_data;
    logic [K*IDX_W-1:0]    out_idx;
    logic [CntW-1:0]       out_count;

    modport master (
        output in_valid, in_last, in_mask, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_count
    );

    modport slave (
        input  in_valid, in_last, in_mask, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_count
    );
endinterface

// File: rtl/kbest_stream_sorter.sv
// Streaming K-best selector. Each accepted beat of K lanes is captured (masked lanes become
// all-ones sentinels), bitonic-sorted over one register per compare stage, then merged in a
// single cycle with the running accumulator, which keeps the K smallest {data, idx} keys of
// the current query. The beat flagged last loads the merged list and count into the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : slave side of kbest_stream_sorter_if (beat input, result output)
module kbest_stream_sorter #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned IDX_W  = 15,
    parameter int unsigned K      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kbest_stream_sorter_if.slave bus_io
);
    localparam int unsigned KeyW   = DATA_W + IDX_W;
    localparam int unsigned LogK   = $clog2(K);
    localparam int unsigned NumStg = LogK * (LogK + 1) / 2;
    localparam int unsigned CntW   = LogK + 1;
    localparam logic [CntW:0] KSat = (CntW + 1)'(K);

    typedef logic [KeyW-1:0] key_t;

    // Block size of the bitonic sub-sequence handled by compare stage st.
    function automatic int unsigned stage_kb(input int unsigned st);
        int unsigned n;
        int unsigned r;
        n = 0;
        r = K;
        for (int unsigned kb = 2; kb <= K; kb = kb * 2) begin
            for (int unsigned jb = kb / 2; jb >= 1; jb = jb / 2) begin
                if (n == st) r = kb;
                n = n + 1;
            end
        end
        return r;
    endfunction

    // Partner distance of compare stage st.
    function automatic int unsigned stage_jb(input int unsigned st);
        int unsigned n;
        int unsigned r;
        n = 0;
        r = 1;
        for (int unsigned kb = 2; kb <= K; kb = kb * 2) begin
            for (int unsigned jb = kb / 2; jb >= 1; jb = jb / 2) begin
                if (n == st) r = jb;
                n = n + 1;
            end
        end
        return r;
    endfunction

    function automatic key_t min_key(input key_t a, input key_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic key_t max_key(input key_t a, input key_t b);
        return (a < b) ? b : a;
    endfunction

    logic                                   en;
    logic [K-1:0][KeyW-1:0]                 cap_w;
    logic [NumStg-1:0][K-1:0][KeyW-1:0]     net_w;
    logic [NumStg:0][K-1:0][KeyW-1:0]       stg_q;
    logic [NumStg:0]                        vld_q;
    logic [NumStg:0]                        last_q;
    logic [NumStg:0][CntW-1:0]              pop_q;
    logic [K-1:0][KeyW-1:0]                 beat_w;
    logic [K-1:0][KeyW-1:0]                 hc_w;
    logic [LogK:0][K-1:0][KeyW-1:0]         cln_w;
    logic [K-1:0][KeyW-1:0]                 mrg_w;
    logic [K-1:0][KeyW-1:0]                 acc_q, acc_d;
    logic [K-1:0][KeyW-1:0]                 res_q, res_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic [CntW-1:0]                        res_cnt_q, res_cnt_d;
    logic [CntW-1:0]                        cnt_base;
    logic [CntW-1:0]                        cnt_new;
    logic [CntW:0]                          cnt_sum;
    logic                                   first_q, first_d;
    logic                                   out_valid_q, out_valid_d;

    // A result waiting on a stalled consumer freezes the whole datapath.
    assign en              = !(out_valid_q && !bus_io.out_ready);
    assign bus_io.in_ready = en;

    for (genvar i = 0; i < K; i++) begin : g_cap
        assign cap_w[i] = bus_io.in_mask[i]
                        ? {bus_io.in_data[i*DATA_W +: DATA_W], bus_io.in_idx[i*IDX_W +: IDX_W]}
                        : '1;
    end

    // Bitonic sort network; stage st reads register st and feeds register st+1.
    for (genvar st = 0; st < NumStg; st++) begin : g_stage
        localparam int unsigned Kb = stage_kb(st);
        localparam int unsigned Jb = stage_jb(st);
        for (genvar i = 0; i < K; i++) begin : g_lane
            localparam int unsigned Partner = i ^ Jb;
            localparam bit TakeMin = ((i < Partner) == ((i & Kb) == 0));
            if (TakeMin) begin : g_min
                assign net_w[st][i] = min_key(stg_q[st][i], stg_q[st][Partner]);
            end else begin : g_max
                assign net_w[st][i] = max_key(stg_q[st][i], stg_q[st][Partner]);
            end
        end
    end

    // Half-cleaner against the reversed accumulator leaves the K minima as a bitonic list;
    // the first beat of a query merges against all sentinels instead of stale state.
    assign beat_w = stg_q[NumStg];
    for (genvar i = 0; i < K; i++) begin : g_hc
        assign hc_w[i] = min_key(beat_w[i], first_q ? '1 : acc_q[K-1-i]);
    end
    assign cln_w[0] = hc_w;

    for (genvar l = 0; l < LogK; l++) begin : g_clean
        localparam int unsigned Jm = K >> (l + 1);
        for (genvar i = 0; i < K; i++) begin : g_lane
            localparam int unsigned Partner = i ^ Jm;
            if (i < Partner) begin : g_min
                assign cln_w[l+1][i] = min_key(cln_w[l][i], cln_w[l][Partner]);
            end else begin : g_max
                assign cln_w[l+1][i] = max_key(cln_w[l][i], cln_w[l][Partner]);
            end
        end
    end
    assign mrg_w = cln_w[LogK];

    assign cnt_base = first_q ? '0 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + {1'b0, pop_q[NumStg]};
    assign cnt_new  = (cnt_sum > KSat) ? CntW'(K) : cnt_sum[CntW-1:0];

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (en && vld_q[NumStg]) begin
            acc_d   = mrg_w;
            cnt_d   = cnt_new;
            first_d = last_q[NumStg];
            if (last_q[NumStg]) begin
                res_d       = mrg_w;
                res_cnt_d   = cnt_new;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q       <= '0;
            vld_q       <= '0;
            last_q      <= '0;
            pop_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            res_q       <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (en) begin
                stg_q  <= {net_w, cap_w};
                vld_q  <= {vld_q[NumStg-1:0], bus_io.in_valid};
                last_q <= {last_q[NumStg-1:0], bus_io.in_valid && bus_io.in_last};
                pop_q  <= {pop_q[NumStg-1:0], CntW'($countones(bus_io.in_mask))};
            end
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_count = res_cnt_q;
    for (genvar i = 0; i < K; i++) begin : g_out
        assign bus_io.out_data[i*DATA_W +: DATA_W] = res_q[i][KeyW-1:IDX_W];
        assign bus_io.out_idx[i*IDX_W +: IDX_W]    = res_q[i][IDX_W-1:0];
    end
endmodule

// File: tb/tb_kbest_stream_sorter.sv
// Directed bench for kbest_stream_sorter (K=4). A reference model collects the unmasked
// keys of each query, sorts them and pushes the expected result; a monitor pops and
// compares on every output handshake.
module tb_kbest_stream_sorter;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned IDX_W  = 15;
    localparam int unsigned K      = 4;
    localparam int unsigned KeyW   = DATA_W + IDX_W;
    localparam int unsigned CntW   = $clog2(K) + 1;

    typedef logic [KeyW-1:0] key_t;
    typedef struct {
        logic [K*DATA_W-1:0] d;
        logic [K*IDX_W-1:0]  x;
        logic [CntW-1:0]     c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;
    exp_t exp_q[$];
    key_t cand[$];

    always #5 clk = ~clk;

    kbest_stream_sorter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K)) bus ();

    kbest_stream_sorter #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic close_query();
        exp_t e;
        key_t k;
        cand.sort();
        for (int i = 0; i < K; i++) begin
            k = (i < cand.size()) ? cand[i] : '1;
            e.d[i*DATA_W +: DATA_W] = k[KeyW-1:IDX_W];
            e.x[i*IDX_W +: IDX_W]   = k[IDX_W-1:0];
        end
        e.c = (cand.size() > K) ? CntW'(K) : CntW'(cand.size());
        exp_q.push_back(e);
        cand.delete();
    endtask

    // Drives one beat, waits (bounded) for acceptance, updates the model on the accept edge.
    task automatic send(input logic last, input logic [K-1:0] mask,
                        input int d[K], input int x[K]);
        int w;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_mask  = mask;
        for (int i = 0; i < K; i++) begin
            bus.in_data[i*DATA_W +: DATA_W] = DATA_W'(d[i]);
            bus.in_idx[i*IDX_W +: IDX_W]    = IDX_W'(x[i]);
        end
        w = 0;
        #1;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("beat_accept", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) begin
            @(posedge clk);
            for (int i = 0; i < K; i++) begin
                if (mask[i]) cand.push_back({DATA_W'(d[i]), IDX_W'(x[i])});
            end
            if (last) close_query();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        #2;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every output handshake must match the oldest expected result.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e.d));
                chk("out_idx", 64'(bus.out_idx), 64'(e.x));
                chk("out_count", 64'(bus.out_count), 64'(e.c));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_mask   = '0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
        chk("rst_out_count", 64'(bus.out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single beat query, latency and one-cycle pulse
        @(negedge clk);
        bus.out_ready = 1'b1;
        send(1'b1, 4'b1111, '{9, 3, 7, 1}, '{10, 11, 12, 13});
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("latency", 64'(n), 64'd4);
        @(negedge clk);
        #1;
        chk("pulse_drop", 64'(bus.out_valid), 64'd0);

        // Two-beat query immediately followed by a tie-breaking query
        @(negedge clk);
        send(1'b0, 4'b1111, '{50, 40, 30, 20}, '{0, 1, 2, 3});
        send(1'b1, 4'b1111, '{5, 60, 25, 45}, '{4, 5, 6, 7});
        send(1'b1, 4'b1111, '{2, 2, 2, 2}, '{3, 1, 2, 0});
        drain();

        // Partial mask, then fully masked query
        @(negedge clk);
        send(1'b1, 4'b0011, '{6, 2, 0, 0}, '{0, 1, 2, 3});
        send(1'b1, 4'b0000, '{1, 1, 1, 1}, '{1, 1, 1, 1});
        drain();

        // Backpressure: result held while the next query stalls at the input
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(1'b1, 4'b1111, '{100, 7, 300, 7}, '{1, 2, 3, 0});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        fork
            begin
                send(1'b0, 4'b1111, '{12, 11, 10, 9}, '{20, 21, 22, 23});
                send(1'b1, 4'b1011, '{1, 500, 8, 3}, '{30, 31, 32, 33});
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("bp_hold_data", 64'(bus.out_data), 64'(exp_q[0].d));
                    chk("bp_hold_idx", 64'(bus.out_idx), 64'(exp_q[0].x));
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a query discards it
        @(negedge clk);
        send(1'b0, 4'b1111, '{0, 1, 2, 3}, '{0, 1, 2, 3});
        send(1'b0, 4'b1111, '{4, 5, 6, 7}, '{4, 5, 6, 7});
        rst_n = 1'b0;
        cand.delete();
        #1;
        chk("abort_rst_valid", 64'(bus.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk);
        send(1'b1, 4'b1111, '{40, 30, 20, 10}, '{4, 3, 2, 1});
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
